// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
interface data_mem_responder_if;
  logic        req;
  logic        RW;
  logic [31:0] add_bus;
  logic [31:0] data_bus;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, RW, add_bus, data_bus,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, RW, add_bus, data_bus,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers each request with a one-cycle ready
// strobe after a fixed number of wait states; out-of-range addresses flag err.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];
  logic        in_range;
  logic        mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          rw_d    = bus.RW;
          addr_d  = bus.add_bus;
          wdata_d = bus.data_bus;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Commit uses the _d copies: with zero wait states the RESP-entry edge is
  // also the acceptance edge, so the _q registers are not yet loaded.
  always_comb begin
    mem_we = (state_d == RESP) && (state_q != RESP) && !rw_d && (addr_d < 32'(DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[addr_d[AW-1:0]] <= wdata_d;
    end
  end

  always_comb begin
    in_range  = addr_q < 32'(DEPTH);
    bus.ready = (state_q == RESP);
    bus.busy  = (state_q != IDLE);
    bus.err   = (state_q == RESP) && !in_range;
    bus.rdata = '0;
    if ((state_q == RESP) && rw_q && in_range) begin
      bus.rdata = mem[addr_q[AW-1:0]];
    end
  end

endmodule
